// File: rtl/seg_scan_counter.sv
// Cursor-addressed N-digit counter with a time-multiplexed seven-segment scan; sel/seg registered, 1 clk behind index/value.
// Define SEG_CARRY_EN to ripple carry/borrow from the cursor digit into higher digits.
module seg_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_MAX  = 9,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_inc,
  input  logic                    btn_dec,
  input  logic                    btn_left,
  input  logic                    btn_right,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   cursor,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [7:0]              seg
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0]      MAXV     = 4'(DIGIT_MAX);
  localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [3:0]              btn_q, btn_now, btn_edge;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   cursor_q, cursor_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DW-1:0]           div_q, div_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]              seg_q;
  logic                    do_inc, do_dec, mv_l, mv_r;
  logic [3:0]              dig, scan_dig;
  logic                    hit, wrap, scan_cur;
`ifdef SEG_CARRY_EN
  logic                    carry;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  assign btn_now  = {btn_right, btn_left, btn_dec, btn_inc};
  assign btn_edge = btn_now & ~btn_q;
  // Opposing edges in the same cycle cancel each other.
  assign do_inc   = btn_edge[0] & ~btn_edge[1];
  assign do_dec   = btn_edge[1] & ~btn_edge[0];
  assign mv_l     = btn_edge[2] & ~btn_edge[3];
  assign mv_r     = btn_edge[3] & ~btn_edge[2];

  always_comb begin
    cursor_d = cursor_q;
    if (mv_l && !cursor_q[NUM_DIGITS-1])
      cursor_d = cursor_q << 1;
    else if (mv_r && !cursor_q[0])
      cursor_d = cursor_q >> 1;
  end

  // Digit update keys off the pre-edge cursor, so a simultaneous move hits the old digit.
  always_comb begin
    value_d = value_q;
    dig     = 4'd0;
    hit     = 1'b0;
    wrap    = 1'b0;
`ifdef SEG_CARRY_EN
    carry   = 1'b0;
`endif
    for (int d = 0; d < NUM_DIGITS; d++) begin
      dig  = value_q[4*d +: 4];
      wrap = do_inc ? (dig == MAXV) : (dig == 4'd0);
`ifdef SEG_CARRY_EN
      hit   = cursor_q[d] | carry;
      carry = hit & wrap;
`else
      hit   = cursor_q[d];
`endif
      if (hit && (do_inc || do_dec)) begin
        if (do_inc)
          value_d[4*d +: 4] = wrap ? 4'd0 : dig + 4'd1;
        else
          value_d[4*d +: 4] = wrap ? MAXV : dig - 4'd1;
      end
    end
  end

  always_comb begin
    div_d = div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    scan_dig = 4'd0;
    scan_cur = 1'b0;
    sel_d    = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IW'(d)) begin
        scan_dig = value_q[4*d +: 4];
        scan_cur = cursor_q[d];
        sel_d[d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q    <= 4'b0;
      value_q  <= '0;
      cursor_q <= ONE_HOT0;
      idx_q    <= '0;
      div_q    <= '0;
      sel_q    <= ~ONE_HOT0;
      seg_q    <= 8'hFF;
    end else begin
      btn_q    <= btn_now;
      value_q  <= value_d;
      cursor_q <= cursor_d;
      idx_q    <= idx_d;
      div_q    <= div_d;
      sel_q    <= sel_d;
      seg_q    <= {~scan_cur, glyph(scan_dig)};
    end
  end

  assign value  = value_q;
  assign cursor = cursor_q;
  assign sel    = sel_q;
  assign seg    = seg_q;

endmodule

// File: tb/tb_seg_scan_counter.sv
// Scoreboard bench for seg_scan_counter (NUM_DIGITS=4, DIGIT_MAX=9, SCAN_DIV=4).
module tb_seg_scan_counter;

  typedef struct {
    int          kind;
    logic [31:0] expv;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_inc = 1'b0, btn_dec = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [15:0] value;
  logic [3:0]  cursor, sel;
  logic [7:0]  seg;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   tag     = 0;
  exp_t sbq[$];

`ifdef SEG_CARRY_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif

  always #5 clk = ~clk;

  seg_scan_counter #(.NUM_DIGITS(4), .DIGIT_MAX(9), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_left(btn_left), .btn_right(btn_right),
    .value(value), .cursor(cursor), .sel(sel), .seg(seg)
  );

  function automatic string kname(input int k);
    case (k)
      0: return "value";
      1: return "cursor";
      2: return "sel";
      default: return "seg";
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [15:0] nc, input logic [15:0] cy);
    return CARRY ? {16'h0, cy} : {16'h0, nc};
  endfunction

  task automatic exp_push(input int kind, input logic [31:0] v);
    exp_t e;
    e.kind = kind;
    e.expv = v;
    e.tag  = tag;
    tag++;
    sbq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // m = {right, left, dec, inc}
  task automatic press(input logic [3:0] m, input int hold);
    {btn_right, btn_left, btn_dec, btn_inc} = m;
    tick(hold);
    {btn_right, btn_left, btn_dec, btn_inc} = 4'b0;
    tick(2);
  endtask

  // Monitor: compares every queued expectation against the DUT away from the active edge.
  exp_t        me;
  logic [31:0] mact;
  initial begin
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        me = sbq.pop_front();
        case (me.kind)
          0:       mact = {16'h0, value};
          1:       mact = {28'h0, cursor};
          2:       mact = {28'h0, sel};
          default: mact = {24'h0, seg};
        endcase
        n_tests++;
        if (mact !== me.expv) begin
          n_fail++;
          $display("FAIL %s #%0d: got %0h, want %0h", kname(me.kind), me.tag, mact, me.expv);
        end
      end
    end
  end

  logic [3:0] se;
  initial begin
    // Reset state
    #1;
    exp_push(0, 32'h0);
    exp_push(1, 32'h1);
    exp_push(2, 32'hE);
    exp_push(3, 32'hFF);
    @(posedge clk);
    #1 rst = 1'b0;

    // Scan: each select held SCAN_DIV cycles, dp lit on the cursor digit
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      se = 4'b0001 << (((k - 1) / 4) % 4);
      se = ~se;
      exp_push(2, {28'h0, se});
      exp_push(3, (se == 4'hE) ? 32'h40 : 32'hC0);
    end
    exp_push(0, 32'h0);
    exp_push(1, 32'h1);

    // Increment pulses, then a long hold fires only once
    repeat (12) press(4'b0001, 3);
    exp_push(0, pick(16'h0002, 16'h0012));
    btn_inc = 1'b1;
    tick(100);
    exp_push(0, pick(16'h0003, 16'h0013));
    btn_inc = 1'b0;
    tick(2);
    exp_push(0, pick(16'h0003, 16'h0013));

    // Cursor left saturates at MSB, dec wraps 0 -> 9, right saturates at digit 0
    for (int i = 0; i < 5; i++) begin
      press(4'b0100, 2);
      exp_push(1, (i < 3) ? {28'h0, 4'b0010 << i} : 32'h8);
    end
    press(4'b0010, 2);
    exp_push(0, pick(16'h9003, 16'h9013));
    exp_push(1, 32'h8);
    for (int i = 0; i < 4; i++) begin
      press(4'b1000, 2);
      exp_push(1, (i < 3) ? {28'h0, 4'b0100 >> i} : 32'h1);
    end

    // Simultaneous inc+dec cancels; left+inc updates old digit and moves cursor
    press(4'b0011, 2);
    exp_push(0, pick(16'h9003, 16'h9013));
    press(4'b0101, 2);
    exp_push(0, pick(16'h9004, 16'h9014));
    exp_push(1, 32'h2);

    // Fresh reset, scan to digit 1, then async reset between edges
    @(posedge clk);
    #1 rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    exp_push(2, 32'hD);
    exp_push(3, 32'hC0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    exp_push(2, 32'hE);
    exp_push(3, 32'hFF);
    exp_push(0, 32'h0);
    exp_push(1, 32'h1);

    // Button already high at reset release fires exactly once
    btn_inc = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    exp_push(0, 32'h1);
    tick(5);
    exp_push(0, 32'h1);
    btn_inc = 1'b0;
    tick(2);

    // Load 9999, then wrap up and back down, then carry from a non-zero cursor
    repeat (8) press(4'b0001, 2);
    exp_push(0, 32'h0009);
    press(4'b0100, 2);
    repeat (9) press(4'b0001, 2);
    exp_push(0, 32'h0099);
    press(4'b0100, 2);
    repeat (9) press(4'b0001, 2);
    exp_push(0, 32'h0999);
    press(4'b0100, 2);
    repeat (9) press(4'b0001, 2);
    exp_push(0, 32'h9999);
    exp_push(1, 32'h8);
    repeat (3) press(4'b1000, 2);
    exp_push(1, 32'h1);
    press(4'b0001, 2);
    exp_push(0, pick(16'h9990, 16'h0000));
    press(4'b0010, 2);
    exp_push(0, 32'h9999);
    press(4'b0100, 2);
    exp_push(1, 32'h2);
    press(4'b0001, 2);
    exp_push(0, pick(16'h9909, 16'h0009));

    tick(2);
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
